// File: rtl/bfusion_pkg.sv
// rtl/bfusion_pkg.sv - shared types and arithmetic helpers for the BitFusion MAC
package bfusion_pkg;

    typedef enum logic [1:0] {
        MODE_FULL  = 2'b00,
        MODE_HALF  = 2'b01,
        MODE_QUART = 2'b11
    } mode_e;

    function automatic int acc_w(input int a_w, input int w_w, input int headroom);
        return a_w + w_w + headroom;
    endfunction

    // Operands are sign-extended to 64 bits; the result is clamped to a signed width-bit range.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                    input logic signed [63:0] b,
                                                    input int width);
        logic signed [64:0] s;
        logic signed [64:0] mx;
        logic signed [64:0] mn;
        logic signed [64:0] r;
        s  = {a[63], a} + {b[63], b};
        mx = (65'sd1 <<< (width - 1)) - 65'sd1;
        mn = -(65'sd1 <<< (width - 1));
        if (s > mx)      r = mx;
        else if (s < mn) r = mn;
        else             r = s;
        return r[63:0];
    endfunction

endpackage

// File: rtl/bfusion_fused_mult.sv
// rtl/bfusion_fused_mult.sv - combinational fused multiplier: unsigned slices times signed sub-weights
module bfusion_fused_mult
    import bfusion_pkg::*;
#(
    parameter int A_W = 8,
    parameter int W_W = 8,
    localparam int PW = A_W + W_W + 2
) (
    input  logic [4*A_W-1:0]     a_i,
    input  logic [W_W-1:0]       w_i,
    input  logic [1:0]           mode_i,
    output logic signed [PW-1:0] p_o
);

    localparam int H = W_W / 2;
    localparam int Q = W_W / 4;

    logic signed [PW-1:0] act [4];
    logic signed [PW-1:0] wq  [4];
    logic signed [PW-1:0] wh  [2];
    logic signed [PW-1:0] wf;

    always_comb begin
        p_o = '0;
        for (int i = 0; i < 4; i++) begin
            act[i] = PW'({1'b0, a_i[i*A_W +: A_W]});
            wq[i]  = PW'($signed(w_i[i*Q +: Q]));
        end
        wh[0] = PW'($signed(w_i[H-1:0]));
        wh[1] = PW'($signed(w_i[W_W-1:H]));
        wf    = PW'($signed(w_i));
        // The reserved encoding falls through to full precision.
        case (mode_i)
            MODE_HALF:  p_o = act[0] * wh[0] + act[1] * wh[1];
            MODE_QUART: begin
                for (int i = 0; i < 4; i++) begin
                    p_o = p_o + act[i] * wq[i];
                end
            end
            default:    p_o = act[0] * wf;
        endcase
    end

endmodule

// File: rtl/mac_bfusion1d_stream.sv
// rtl/mac_bfusion1d_stream.sv - streaming 1D BitFusion MAC with grouped accumulation and held output
module mac_bfusion1d_stream
    import bfusion_pkg::*;
#(
    parameter int A_W      = 8,
    parameter int W_W      = 8,
    parameter int HEADROOM = 4,
    parameter int LEN_W    = 8,
    parameter int SATURATE = 0,
    localparam int ACC_W   = acc_w(A_W, W_W, HEADROOM)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4*A_W-1:0]        a,
    input  logic [W_W-1:0]          w,
    input  logic [1:0]              mode,
    input  logic [LEN_W-1:0]        acc_len,
    output logic                    z_valid,
    input  logic                    z_ready,
    output logic signed [ACC_W-1:0] z
);

    localparam int PW = A_W + W_W + 2;

    logic [LEN_W-1:0]        cnt_q, cnt_d, len_q, len_d;
    logic [1:0]              mode_q, mode_d;
    logic signed [PW-1:0]    p_q, p_d;
    logic                    p_valid_q, p_valid_d, p_last_q, p_last_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, z_q, z_d;
    logic                    z_valid_q, z_valid_d;

    logic                    stall, accept, beat_last;
    logic [1:0]              beat_mode;
    logic [LEN_W-1:0]        beat_len;
    logic signed [PW-1:0]    prod;
    logic signed [63:0]      acc_x, p_x, sum_x;
    logic signed [ACC_W-1:0] sum;

    bfusion_fused_mult #(.A_W(A_W), .W_W(W_W)) u_mult (
        .a_i    (a),
        .w_i    (w),
        .mode_i (beat_mode),
        .p_o    (prod)
    );

    always_comb begin
        stall     = p_valid_q & p_last_q & z_valid_q & ~z_ready;
        accept    = in_valid & ~stall;
        // Group parameters come straight from the inputs only on the first beat.
        beat_mode = (cnt_q == '0) ? mode : mode_q;
        beat_len  = (cnt_q == '0) ? ((acc_len == '0) ? LEN_W'(1) : acc_len) : len_q;
        beat_last = (cnt_q == beat_len - LEN_W'(1));

        acc_x = 64'(acc_q);
        p_x   = 64'(p_q);
        if (SATURATE != 0) sum_x = sat_add(acc_x, p_x, ACC_W);
        else               sum_x = acc_x + p_x;
        sum = sum_x[ACC_W-1:0];

        cnt_d     = cnt_q;
        len_d     = len_q;
        mode_d    = mode_q;
        p_d       = p_q;
        p_valid_d = p_valid_q;
        p_last_d  = p_last_q;
        acc_d     = acc_q;
        z_d       = z_q;
        z_valid_d = z_valid_q;

        if (accept) begin
            cnt_d = beat_last ? '0 : cnt_q + LEN_W'(1);
            if (cnt_q == '0) begin
                mode_d = mode;
                len_d  = beat_len;
            end
        end
        if (!stall) begin
            p_valid_d = accept;
            p_last_d  = beat_last;
            p_d       = prod;
        end
        if (z_valid_q && z_ready) z_valid_d = 1'b0;
        if (p_valid_q && !stall) begin
            if (p_last_q) begin
                z_d       = sum;
                z_valid_d = 1'b1;
                acc_d     = '0;
            end else begin
                acc_d = sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            len_q     <= '0;
            mode_q    <= MODE_FULL;
            p_q       <= '0;
            p_valid_q <= 1'b0;
            p_last_q  <= 1'b0;
            acc_q     <= '0;
            z_q       <= '0;
            z_valid_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            mode_q    <= mode_d;
            p_q       <= p_d;
            p_valid_q <= p_valid_d;
            p_last_q  <= p_last_d;
            acc_q     <= acc_d;
            z_q       <= z_d;
            z_valid_q <= z_valid_d;
        end
    end

    assign in_ready = ~stall;
    assign z_valid  = z_valid_q;
    assign z        = z_q;

endmodule

// File: tb/tb_mac_bfusion1d_stream.sv
// tb/tb_mac_bfusion1d_stream.sv - scoreboard bench for wrap and saturating MAC instances
module tb_mac_bfusion1d_stream;

    logic        clk, rst, in_valid, z_ready;
    logic [31:0] a;
    logic [7:0]  w, acc_len;
    logic [1:0]  mode;
    logic        in_ready0, z_valid0, in_ready1, z_valid1;
    logic [19:0] z0, z1;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    longint q0[$];
    longint q1[$];
    int     m_cnt, m_len;
    logic [1:0] m_mode;
    longint m_acc0, m_acc1;

    mac_bfusion1d_stream #(.SATURATE(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .a(a), .w(w),
        .mode(mode), .acc_len(acc_len), .z_valid(z_valid0), .z_ready(z_ready), .z(z0)
    );
    mac_bfusion1d_stream #(.SATURATE(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .a(a), .w(w),
        .mode(mode), .acc_len(acc_len), .z_valid(z_valid1), .z_ready(z_ready), .z(z1)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(string name, longint act, longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic longint model_prod(logic [31:0] av, logic [7:0] wv, logic [1:0] mv);
        longint s;
        s = 0;
        if (mv == 2'b01) begin
            for (int i = 0; i < 2; i++) begin
                logic [3:0] nib;
                nib = wv[i*4 +: 4];
                s += longint'(av[i*8 +: 8]) * longint'($signed(nib));
            end
        end else if (mv == 2'b11) begin
            for (int i = 0; i < 4; i++) begin
                logic [1:0] cr;
                cr = wv[i*2 +: 2];
                s += longint'(av[i*8 +: 8]) * longint'($signed(cr));
            end
        end else begin
            s = longint'(av[7:0]) * longint'($signed(wv));
        end
        return s;
    endfunction

    function automatic longint fold(longint v, bit sat);
        longint r;
        if (sat) begin
            r = (v > 524287) ? 524287 : ((v < -524288) ? -524288 : v);
        end else begin
            r = v & 64'hFFFFF;
            if (r >= 524288) r -= 1048576;
        end
        return r;
    endfunction

    task automatic mon();
        longint e;
        forever begin
            @(negedge clk);
            cyc++;
            if (cyc > 60000) begin
                $display("FAIL watchdog: cycle %0d exceeded limit 60000", cyc);
                $fatal(1);
            end
            if (rst) begin
                m_cnt = 0; m_acc0 = 0; m_acc1 = 0;
                q0.delete(); q1.delete();
            end else begin
                if (in_valid && in_ready0) begin
                    longint p;
                    if (m_cnt == 0) begin
                        m_mode = mode;
                        m_len  = (acc_len == 0) ? 1 : int'(acc_len);
                    end
                    p      = model_prod(a, w, m_mode);
                    m_acc0 = fold(m_acc0 + p, 1'b0);
                    m_acc1 = fold(m_acc1 + p, 1'b1);
                    m_cnt++;
                    if (m_cnt == m_len) begin
                        q0.push_back(m_acc0);
                        q1.push_back(m_acc1);
                        m_cnt = 0; m_acc0 = 0; m_acc1 = 0;
                    end
                end
                if (z_valid0 && z_ready) begin
                    if (q0.size() == 0) check("sb_wrap_underflow", 1, 0);
                    else begin e = q0.pop_front(); check("sb_wrap", longint'($signed(z0)), e); end
                end
                if (z_valid1 && z_ready) begin
                    if (q1.size() == 0) check("sb_sat_underflow", 1, 0);
                    else begin e = q1.pop_front(); check("sb_sat", longint'($signed(z1)), e); end
                end
            end
        end
    endtask

    task automatic send(logic [31:0] av, logic [7:0] wv, logic [1:0] mv, logic [7:0] lv);
        int t;
        a = av; w = wv; mode = mv; acc_len = lv; in_valid = 1;
        t = 0;
        @(negedge clk);
        while (!in_ready0 && t < 500) begin
            t++;
            @(negedge clk);
        end
        if (t >= 500) check("send_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic idle();
        in_valid = 0;
    endtask

    task automatic drain();
        int t;
        in_valid = 0; z_ready = 1; t = 0;
        @(negedge clk);
        while ((q0.size() != 0 || q1.size() != 0 || z_valid0 || z_valid1) && t < 300) begin
            t++;
            @(negedge clk);
        end
        if (t >= 300) check("drain_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_z(string name, longint e0, longint e1);
        int t;
        t = 0;
        @(negedge clk);
        while (!z_valid0 && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (t >= 200) check({name, "_timeout"}, 0, 1);
        else begin
            check({name, "_wrap"}, longint'(z0), e0);
            check({name, "_sat"},  longint'(z1), e1);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        fork
            mon();
        join_none
        rst = 1; in_valid = 0; z_ready = 1; a = 0; w = 0; mode = 0; acc_len = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("rst_z_valid", longint'(z_valid0), 0);
        check("rst_z", longint'(z0), 0);
        check("rst_in_ready", longint'(in_ready0), 1);
        check("rst_sat_z_valid", longint'(z_valid1), 0);
        @(posedge clk); #1;

        // Full mode latency: z_valid rises exactly two edges after acceptance.
        a = 32'h000000FF; w = 8'h80; mode = 2'b00; acc_len = 1; in_valid = 1;
        @(negedge clk);
        check("lat_in_ready", longint'(in_ready0), 1);
        @(posedge clk); #1 in_valid = 0;
        @(negedge clk);
        check("lat_edge1_z_valid", longint'(z_valid0), 0);
        @(negedge clk);
        check("lat_edge2_z_valid", longint'(z_valid0), 1);
        check("full_z", longint'(z0), 64'hF8080);
        @(posedge clk); #1;
        drain();

        // Half mode, four-beat group.
        for (int i = 0; i < 4; i++) begin
            send(32'h00001020, 8'h7F, 2'b01, 8'd4);
            check("half_group_z_valid_low", longint'(z_valid0), 0);
        end
        idle();
        wait_z("half_z", 64'h00140, 64'h00140);
        drain();

        // Quarter mode, then a group where mode/acc_len change mid-group.
        send(32'h01020304, 8'hE4, 2'b11, 8'd1);
        idle();
        wait_z("quart_z", 64'hFFFFE, 64'hFFFFE);
        send(32'h01020304, 8'hE4, 2'b11, 8'd3);
        send(32'h01020304, 8'hE4, 2'b00, 8'd1);
        send(32'h01020304, 8'hE4, 2'b00, 8'd1);
        idle();
        wait_z("mode_ignored_z", 64'hFFFFA, 64'hFFFFA);
        drain();

        // Backpressure with three back-to-back single-beat groups.
        z_ready = 0;
        send(32'd1, 8'd1, 2'b00, 8'd1);
        send(32'd2, 8'd1, 2'b00, 8'd1);
        a = 32'd3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_in_ready_low", longint'(in_ready0), 0);
            check("bp_z_held", longint'(z0), 1);
            check("bp_z_valid", longint'(z_valid0), 1);
        end
        @(posedge clk); #1 z_ready = 1;
        send(32'd3, 8'd1, 2'b00, 8'd1);
        idle();
        drain();

        // Overflow of a 17-beat group: wrap vs clamp.
        for (int i = 0; i < 17; i++) send(32'h000000FF, 8'h7F, 2'b00, 8'd17);
        idle();
        wait_z("sat17_z", 64'h86691, 64'h7FFFF);
        drain();

        // Reset in the middle of a group discards partial state.
        send(32'd5, 8'd3, 2'b00, 8'd4);
        send(32'd5, 8'd3, 2'b00, 8'd4);
        idle();
        rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        check("midrst_z_valid", longint'(z_valid0), 0);
        check("midrst_z", longint'(z0), 0);
        check("midrst_in_ready", longint'(in_ready0), 1);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) send(32'd1, 8'd2, 2'b00, 8'd4);
        idle();
        wait_z("postrst_z", 64'h8, 64'h8);
        drain();

        // Randomized traffic with bubbles, backpressure and mid-group parameter churn.
        for (int i = 0; i < 1500; i++) begin
            in_valid = ($urandom_range(0, 9) < 7);
            z_ready  = ($urandom_range(0, 9) < 6);
            a        = $urandom;
            w        = 8'($urandom);
            mode     = 2'($urandom);
            acc_len  = 8'($urandom_range(0, 4));
            @(posedge clk); #1;
        end
        drain();
        check("final_q_wrap_empty", longint'(q0.size()), 0);
        check("final_q_sat_empty",  longint'(q1.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
